// File: rtl/ps2_key_ctrl.sv
// PS/2 keyboard receive controller: filtered clock, 11-bit frame receive,
// E0/F0 prefix decode, and a held-key map of the game controls.
module ps2_key_ctrl #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 2500
) (
  input  logic        clk25,
  input  logic        rst_n,
  input  logic        PS2C,
  input  logic        PS2D,
  output logic [15:0] key_code,
  output logic        key_valid,
  output logic        key_break,
  output logic [5:0]  keys_held,
  output logic        frame_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t state, nxt;

  logic                  c_s1, c_s2;
  logic                  d_s1, d_s2;
  logic [FILTER_LEN-1:0] flt;
  logic                  clkf;
  logic                  fall;
  logic [3:0]            bitcnt;
  logic [10:0]           frame;
  logic [TW-1:0]         tocnt;
  logic                  timeout;
  logic                  ext, brk;

  logic                  start_frm;
  logic                  shift_en;
  logic                  err_to;
  logic                  chk;
  logic                  frm_ok;
  logic [7:0]            d;
  logic                  is_e0, is_f0;
  logic                  evt;
  logic [15:0]           code_n;
  logic [5:0]            hit;

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      c_s1 <= 1'b1;
      c_s2 <= 1'b1;
      d_s1 <= 1'b1;
      d_s2 <= 1'b1;
    end else begin
      c_s1 <= PS2C;
      c_s2 <= c_s1;
      d_s1 <= PS2D;
      d_s2 <= d_s1;
    end
  end

  // Filtered clock only changes once the whole window agrees.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      flt  <= '1;
      clkf <= 1'b1;
    end else begin
      flt <= {flt[FILTER_LEN-2:0], c_s2};
      if (&flt)
        clkf <= 1'b1;
      else if (~|flt)
        clkf <= 1'b0;
    end
  end

  assign fall    = clkf & ~|flt;
  assign timeout = (tocnt == TW'(TIMEOUT));

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (fall)
          nxt = SHIFT;
      end
      SHIFT: begin
        if (timeout)
          nxt = IDLE;
        else if (fall && bitcnt == 4'd10)
          nxt = CHECK;
      end
      CHECK:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign d      = frame[8:1];
  assign frm_ok = ~frame[0] & frame[10] & (^frame[9:1]);
  assign is_e0  = (d == 8'hE0);
  assign is_f0  = (d == 8'hF0);
  assign code_n = {ext ? 8'hE0 : 8'h00, d};

  always_comb begin
    start_frm = 1'b0;
    shift_en  = 1'b0;
    err_to    = 1'b0;
    chk       = 1'b0;
    unique case (state)
      IDLE:  start_frm = fall;
      SHIFT: begin
        err_to   = timeout;
        shift_en = fall & ~timeout;
      end
      CHECK: chk = 1'b1;
      default: ;
    endcase
  end

  assign evt = chk & frm_ok & ~is_e0 & ~is_f0;

  always_comb begin
    hit = 6'b0;
    unique case (1'b1)
      (code_n == 16'hE06B): hit = 6'b000001;
      (code_n == 16'hE074): hit = 6'b000010;
      (code_n == 16'hE075): hit = 6'b000100;
      (code_n == 16'hE072): hit = 6'b001000;
      (code_n == 16'h0029): hit = 6'b010000;
      (code_n == 16'h005A): hit = 6'b100000;
      default:              hit = 6'b0;
    endcase
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      bitcnt <= 4'd0;
      frame  <= '1;
      tocnt  <= '0;
    end else begin
      if (start_frm) begin
        frame[0] <= d_s2;
        bitcnt   <= 4'd1;
        tocnt    <= '0;
      end else if (shift_en) begin
        frame[bitcnt] <= d_s2;
        bitcnt        <= bitcnt + 4'd1;
        tocnt         <= '0;
      end else if (state == SHIFT && !timeout) begin
        tocnt <= tocnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      ext       <= 1'b0;
      brk       <= 1'b0;
      key_code  <= 16'h0000;
      key_valid <= 1'b0;
      key_break <= 1'b0;
      keys_held <= 6'b0;
      frame_err <= 1'b0;
    end else begin
      key_valid <= evt;
      frame_err <= err_to | (chk & ~frm_ok);
      if (err_to || (chk && !frm_ok)) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (chk && is_e0) begin
        ext <= 1'b1;
      end else if (chk && is_f0) begin
        brk <= 1'b1;
      end else if (evt) begin
        key_code  <= code_n;
        key_break <= brk;
        keys_held <= brk ? (keys_held & ~hit) : (keys_held | hit);
        ext       <= 1'b0;
        brk       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Scoreboard bench for ps2_key_ctrl: frames are bit-banged on PS2C/PS2D
// and expected key events are queued as frames are sent.
module tb_ps2_key_ctrl;

  logic        clk25 = 1'b0;
  logic        rst_n;
  logic        PS2C;
  logic        PS2D;
  logic [15:0] key_code;
  logic        key_valid;
  logic        key_break;
  logic [5:0]  keys_held;
  logic        frame_err;

  int checks = 0;
  int errors = 0;
  int ferr_cnt = 0;
  logic [5:0] held_m = 6'b0;
  logic [22:0] q[$];

  always #20 clk25 = ~clk25;

  ps2_key_ctrl #(.FILTER_LEN(8), .TIMEOUT(2500)) dut (
    .clk25(clk25),
    .rst_n(rst_n),
    .PS2C(PS2C),
    .PS2D(PS2D),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_break(key_break),
    .keys_held(keys_held),
    .frame_err(frame_err)
  );

  always @(negedge clk25) begin
    if (rst_n && frame_err)
      ferr_cnt++;
    if (rst_n && key_valid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_key_valid code=%h brk=%b",
                 key_code, key_break);
      end else begin
        logic [22:0] e;
        e = q.pop_front();
        if ({key_code, key_break, keys_held} !== e) begin
          errors++;
          $display("FAIL key_event got=%h/%b/%b want=%h/%b/%b",
                   key_code, key_break, keys_held,
                   e[22:7], e[6], e[5:0]);
        end
      end
    end
  end

  function automatic logic [5:0] map(input logic [15:0] c);
    case (c)
      16'hE06B: return 6'b000001;
      16'hE074: return 6'b000010;
      16'hE075: return 6'b000100;
      16'hE072: return 6'b001000;
      16'h0029: return 6'b010000;
      16'h005A: return 6'b100000;
      default:  return 6'b000000;
    endcase
  endfunction

  task automatic expect_evt(input logic [15:0] c, input logic b);
    if (b)
      held_m = held_m & ~map(c);
    else
      held_m = held_m | map(c);
    q.push_back({c, b, held_m});
  endtask

  task automatic ps2_bit(input logic b, input bit glitch);
    @(negedge clk25);
    PS2D = b;
    if (glitch) begin
      repeat (18) @(negedge clk25);
      PS2C = 1'b0;
      repeat (3) @(negedge clk25);
      PS2C = 1'b1;
      repeat (19) @(negedge clk25);
    end else begin
      repeat (40) @(negedge clk25);
    end
    PS2C = 1'b0;
    repeat (40) @(negedge clk25);
    PS2C = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] dv, input bit bad_par,
                           input bit glitch);
    logic par;
    par = ~(^dv) ^ bad_par;
    ps2_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++)
      ps2_bit(dv[i], glitch);
    ps2_bit(par, glitch);
    ps2_bit(1'b1, glitch);
    repeat (60) @(negedge clk25);
  endtask

  task automatic drained(input string nm);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s pending=%0d want=0", nm, q.size());
      q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    PS2C  = 1'b1;
    PS2D  = 1'b1;
    repeat (3) @(negedge clk25);
    checks++;
    if ({key_code, key_valid, key_break, keys_held, frame_err} !== 25'b0) begin
      errors++;
      $display("FAIL reset_state got=%h/%b/%b/%b/%b want=0",
               key_code, key_valid, key_break, keys_held, frame_err);
    end
    rst_n = 1'b1;
    repeat (20) @(negedge clk25);
  endtask

  task automatic test_make();
    int f0;
    f0 = ferr_cnt;
    expect_evt(16'h0029, 1'b0);
    send_byte(8'h29, 1'b0, 1'b0);
    drained("make_space");
    checks++;
    if (keys_held !== 6'b010000) begin
      errors++;
      $display("FAIL make_held got=%b want=010000", keys_held);
    end
    checks++;
    if (ferr_cnt != f0) begin
      errors++;
      $display("FAIL make_ferr got=%0d want=%0d", ferr_cnt, f0);
    end
  endtask

  task automatic test_extended();
    expect_evt(16'hE074, 1'b0);
    send_byte(8'hE0, 1'b0, 1'b0);
    send_byte(8'h74, 1'b0, 1'b0);
    drained("ext_make");
    checks++;
    if (keys_held[1] !== 1'b1) begin
      errors++;
      $display("FAIL ext_make_held got=%b want=1", keys_held[1]);
    end
    expect_evt(16'hE074, 1'b1);
    send_byte(8'hE0, 1'b0, 1'b0);
    send_byte(8'hF0, 1'b0, 1'b0);
    send_byte(8'h74, 1'b0, 1'b0);
    drained("ext_break");
    checks++;
    if (keys_held[1] !== 1'b0 || key_code !== 16'hE074) begin
      errors++;
      $display("FAIL ext_break_hold got=%b/%h want=0/e074",
               keys_held[1], key_code);
    end
  endtask

  task automatic test_parity();
    int f0;
    f0 = ferr_cnt;
    send_byte(8'h29, 1'b1, 1'b0);
    checks++;
    if (ferr_cnt != f0 + 1) begin
      errors++;
      $display("FAIL parity_ferr got=%0d want=%0d", ferr_cnt, f0 + 1);
    end
    checks++;
    if (keys_held !== held_m) begin
      errors++;
      $display("FAIL parity_held got=%b want=%b", keys_held, held_m);
    end
    expect_evt(16'h005A, 1'b0);
    send_byte(8'h5A, 1'b0, 1'b0);
    drained("after_parity");
    checks++;
    if (keys_held[5] !== 1'b1) begin
      errors++;
      $display("FAIL enter_held got=%b want=1", keys_held[5]);
    end
  endtask

  task automatic test_timeout();
    int n;
    n = -1;
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      ps2_bit(1'b1, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk25);
      if (frame_err && n < 0)
        n = i + 41;
    end
    checks++;
    if (n < 2505 || n > 2520) begin
      errors++;
      $display("FAIL timeout_delay got=%0d want=2505..2520", n);
    end
    expect_evt(16'h001C, 1'b0);
    send_byte(8'h1C, 1'b0, 1'b0);
    drained("after_timeout");
  endtask

  task automatic test_glitch();
    int f0;
    f0 = ferr_cnt;
    expect_evt(16'h0029, 1'b1);
    send_byte(8'hF0, 1'b0, 1'b1);
    send_byte(8'h29, 1'b0, 1'b1);
    drained("glitch_break");
    checks++;
    if (ferr_cnt != f0 || keys_held !== 6'b100000) begin
      errors++;
      $display("FAIL glitch_state got=%0d/%b want=%0d/100000",
               ferr_cnt, keys_held, f0);
    end
  endtask

  task automatic test_reset_mid();
    expect_evt(16'h005A, 1'b1);
    send_byte(8'hF0, 1'b0, 1'b0);
    send_byte(8'h5A, 1'b0, 1'b0);
    expect_evt(16'hE06B, 1'b0);
    send_byte(8'hE0, 1'b0, 1'b0);
    send_byte(8'h6B, 1'b0, 1'b0);
    expect_evt(16'hE074, 1'b0);
    send_byte(8'hE0, 1'b0, 1'b0);
    send_byte(8'h74, 1'b0, 1'b0);
    drained("pre_reset");
    checks++;
    if (keys_held !== 6'b000011) begin
      errors++;
      $display("FAIL pre_reset_held got=%b want=000011", keys_held);
    end
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      ps2_bit(i[0], 1'b0);
    @(negedge clk25);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({key_code, key_valid, key_break, keys_held, frame_err} !== 25'b0) begin
      errors++;
      $display("FAIL mid_reset got=%h/%b/%b/%b/%b want=0",
               key_code, key_valid, key_break, keys_held, frame_err);
    end
    held_m = 6'b0;
    repeat (4) @(negedge clk25);
    rst_n = 1'b1;
    repeat (20) @(negedge clk25);
    expect_evt(16'hE06B, 1'b0);
    send_byte(8'hE0, 1'b0, 1'b0);
    send_byte(8'h6B, 1'b0, 1'b0);
    drained("after_reset");
    checks++;
    if (keys_held !== 6'b000001) begin
      errors++;
      $display("FAIL after_reset_held got=%b want=000001", keys_held);
    end
  endtask

  initial begin
    test_reset();
    test_make();
    test_extended();
    test_parity();
    test_timeout();
    test_glitch();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
